// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Start-triggered control-word generator for the Datapath. An accepted start
// pulse in IDLE latches op_sel. The sequencer then steps through the states
// that the latched operation needs, and each step presents one registered
// control word. MUL is a repeated add: R3 counts down the multiplier, and the
// Datapath Z flag seen in M_TEST ends the loop.
//
// Ports
//   clk           system clock
//   reset_b       asynchronous active-low reset; aborts any operation at once
//   start         one-cycle launch pulse, honoured only in IDLE
//   op_sel[2:0]   operation select, latched on an accepted start
//   z_flag        Datapath Z for the control word presented this cycle
//   control_word  registered control word
//                 {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}
//   constant_out  constant to the Datapath (always zero in this revision)
//   busy          high in every non-IDLE state, FIN included
//   done          one-cycle pulse in FIN
//   err           one-cycle pulse in FIN when the latched op was illegal
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int CW_W   = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [2:0]        op_sel,
  input  logic              z_flag,
  output logic [CW_W-1:0]   control_word,
  output logic [DATA_W-1:0] constant_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_M_CLR,
    S_M_CPY,
    S_M_TEST,
    S_M_ADD,
    S_M_DEC,
    S_FIN
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD_A = 3'b000,
    OP_LOAD_B = 3'b001,
    OP_ADD    = 3'b010,
    OP_SUB    = 3'b011,
    OP_CLEAR  = 3'b100,
    OP_MUL    = 3'b101
  } op_t;

  // Control words, field order {DA, AA, BA, MB, FS, MD, RW}.
  localparam logic [CW_W-1:0] CW_NOP    = CW_W'(16'h0000);
  localparam logic [CW_W-1:0] CW_LOAD_A = CW_W'(16'h0003); // R0 <= Data_in
  localparam logic [CW_W-1:0] CW_LOAD_B = CW_W'(16'h2003); // R1 <= Data_in
  localparam logic [CW_W-1:0] CW_ADD    = CW_W'(16'h4089); // R2 <= R0 + R1
  localparam logic [CW_W-1:0] CW_SUB    = CW_W'(16'h4095); // R2 <= R0 - R1
  localparam logic [CW_W-1:0] CW_CLR_R2 = CW_W'(16'h4071); // R2 <= constant 0
  localparam logic [CW_W-1:0] CW_CPY    = CW_W'(16'h6401); // R3 <= R1
  localparam logic [CW_W-1:0] CW_TEST   = CW_W'(16'h0C00); // F = R3, no write
  localparam logic [CW_W-1:0] CW_M_ADD  = CW_W'(16'h4809); // R2 <= R2 + R0
  localparam logic [CW_W-1:0] CW_M_DEC  = CW_W'(16'h6C19); // R3 <= R3 - 1

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [CW_W-1:0] cw_d;
  logic       busy_d, done_d, err_d;

  // Ops 110 and 111 are not defined.
  function automatic logic op_illegal(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // The control word that a state presents for its whole duration.
  function automatic logic [CW_W-1:0] word_for(input state_t st, input logic [2:0] op);
    logic [CW_W-1:0] w;
    w = CW_NOP;
    unique case (st)
      S_EXEC: begin
        case (op)
          OP_LOAD_A: w = CW_LOAD_A;
          OP_LOAD_B: w = CW_LOAD_B;
          OP_ADD:    w = CW_ADD;
          OP_SUB:    w = CW_SUB;
          OP_CLEAR:  w = CW_CLR_R2;
          default:   w = CW_NOP;
        endcase
      end
      S_M_CLR:  w = CW_CLR_R2;
      S_M_CPY:  w = CW_CPY;
      S_M_TEST: w = CW_TEST;
      S_M_ADD:  w = CW_M_ADD;
      S_M_DEC:  w = CW_M_DEC;
      default:  w = CW_NOP; // IDLE and FIN never write
    endcase
    return w;
  endfunction

  // Next-state logic. The outputs are decoded from the next state and then
  // registered. As a result, every output changes on the same edge as the
  // state it belongs to.
  always_comb begin
    // NOTE: every signal driven here gets a default first. A path that left a
    // signal unassigned would infer a latch.
    state_d = state_q;
    op_d    = op_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op_sel;
          if (op_sel == OP_MUL)        state_d = S_M_CLR;
          else if (op_illegal(op_sel)) state_d = S_FIN;
          else                         state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_FIN;
      S_M_CLR:  state_d = S_M_CPY;
      S_M_CPY:  state_d = S_M_TEST;
      // z_flag reflects R3 through MOVA. Zero means the count is exhausted.
      S_M_TEST: state_d = z_flag ? S_FIN : S_M_ADD;
      S_M_ADD:  state_d = S_M_DEC;
      S_M_DEC:  state_d = S_M_TEST;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cw_d   = word_for(state_d, op_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    err_d  = (state_d == S_FIN) && op_illegal(op_d);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      control_word <= CW_NOP;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from values sampled before the edge.
      state_q      <= state_d;
      op_q         <= op_d;
      control_word <= cw_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  assign constant_out = '0;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer. A small behavioural Datapath model
// (eight 8-bit registers, a function unit and a Z flag) closes the MUL loop.
// Expected register contents and step counts are worked out by hand.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_sel = 3'b000;
  logic        z_flag;
  logic [15:0] control_word;
  logic [7:0]  constant_out;
  logic        busy, done, err;

  always #5 clk = ~clk;

  alu_op_sequencer #(.CW_W(16), .DATA_W(8)) dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .start        (start),
    .op_sel       (op_sel),
    .z_flag       (z_flag),
    .control_word (control_word),
    .constant_out (constant_out),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // ---------------- Datapath model ----------------
  logic [7:0] dp_r [8];
  logic [7:0] data_in = 8'h00;
  logic [7:0] a_bus, b_bus, f_bus, w_bus;

  always_comb begin
    a_bus = dp_r[control_word[12:10]];
    b_bus = control_word[6] ? constant_out : dp_r[control_word[9:7]];
    case (control_word[5:2])
      4'b0000: f_bus = a_bus;
      4'b0001: f_bus = a_bus + 8'd1;
      4'b0010: f_bus = a_bus + b_bus;
      4'b0011: f_bus = a_bus + b_bus + 8'd1;
      4'b0100: f_bus = a_bus + ~b_bus;
      4'b0101: f_bus = a_bus + ~b_bus + 8'd1;
      4'b0110: f_bus = a_bus - 8'd1;
      4'b1100: f_bus = b_bus;
      default: f_bus = a_bus;
    endcase
    w_bus = control_word[1] ? data_in : f_bus;
  end

  assign z_flag = (f_bus == 8'h00);

  always @(posedge clk)
    if (control_word[0]) dp_r[control_word[15:13]] <= w_bus;

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-operation statistics
  int n_busy;      // busy cycles before the FIN cycle
  int n_writes;    // cycles with RW=1
  int n_madd;      // M_ADD words seen
  int n_done;      // done cycles
  int n_err;       // err cycles
  int n_err_done;  // cycles with err and done together
  logic [15:0] trace [$];

  // Launch one op and follow it until busy falls. If inject_at >= 0, a
  // LOAD_A start pulse is driven at that cycle of the operation.
  task automatic run_op(input logic [2:0] op, input logic [7:0] din, input int inject_at);
    data_in = din;
    op_sel  = op;
    start   = 1'b1;
    step();
    start   = 1'b0;
    n_busy = 0; n_writes = 0; n_madd = 0; n_done = 0; n_err = 0; n_err_done = 0;
    trace.delete();
    for (int cyc = 0; cyc < 1000 && busy; cyc++) begin
      trace.push_back(control_word);
      if (control_word[0]) n_writes++;
      if (control_word == 16'h4809) n_madd++;
      if (err) n_err++;
      if (err && done) n_err_done++;
      if (done) n_done++;
      else n_busy++;
      if (cyc == inject_at) begin
        start  = 1'b1;
        op_sel = 3'b000;
      end
      step();
      start = 1'b0;
    end
    check("op_returns_idle", busy, 1'b0);
    check("idle_word_nop", control_word, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) dp_r[i] = 8'h00;

    // Reset state
    #2;
    check("reset_cw", control_word, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    @(negedge clk);
    reset_b = 1'b1;
    step();

    // LOAD_A 5, LOAD_B -3, ADD
    run_op(3'b000, 8'h05, -1);
    check("load_a_word", trace[0], 16'h0003);
    check("load_a_writes", n_writes, 1);
    check("load_a_done", n_done, 1);
    check("load_a_err", n_err, 0);
    check("load_a_busy", n_busy, 1);
    check("load_a_r0", dp_r[0], 8'h05);

    run_op(3'b001, 8'hFD, -1);
    check("load_b_word", trace[0], 16'h2003);
    check("load_b_writes", n_writes, 1);
    check("load_b_done", n_done, 1);
    check("load_b_r1", dp_r[1], 8'hFD);

    run_op(3'b010, 8'h00, -1);
    check("add_word", trace[0], 16'h4089);
    check("add_writes", n_writes, 1);
    check("add_done", n_done, 1);
    check("add_r2", dp_r[2], 8'h02);

    // SUB: 2 - 7
    run_op(3'b000, 8'h02, -1);
    run_op(3'b001, 8'h07, -1);
    run_op(3'b011, 8'h00, -1);
    check("sub_word", trace[0], 16'h4095);
    check("sub_writes", n_writes, 1);
    check("sub_r2", dp_r[2], 8'hFB);

    // MUL 3 * 4
    run_op(3'b000, 8'h03, -1);
    run_op(3'b001, 8'h04, -1);
    run_op(3'b101, 8'h00, -1);
    check("mul34_busy", n_busy, 15);
    check("mul34_madd", n_madd, 4);
    check("mul34_writes", n_writes, 10);
    check("mul34_done", n_done, 1);
    check("mul34_r2", dp_r[2], 8'h0C);
    check("mul34_r3", dp_r[3], 8'h00);

    // MUL -2 * 3
    run_op(3'b000, 8'hFE, -1);
    run_op(3'b001, 8'h03, -1);
    run_op(3'b101, 8'h00, -1);
    check("mul_neg_busy", n_busy, 12);
    check("mul_neg_r2", dp_r[2], 8'hFA);

    // MUL by zero: M_CLR, M_CPY, M_TEST, FIN
    run_op(3'b001, 8'h00, -1);
    run_op(3'b101, 8'h00, -1);
    check("mul0_len", trace.size(), 4);
    check("mul0_w0", trace[0], 16'h4071);
    check("mul0_w1", trace[1], 16'h6401);
    check("mul0_w2", trace[2], 16'h0C00);
    check("mul0_w3", trace[3], 16'h0000);
    check("mul0_busy", n_busy, 3);
    check("mul0_madd", n_madd, 0);
    check("mul0_r2", dp_r[2], 8'h00);

    // Illegal ops
    run_op(3'b110, 8'h00, -1);
    check("ill6_writes", n_writes, 0);
    check("ill6_done", n_done, 1);
    check("ill6_err", n_err, 1);
    check("ill6_err_done", n_err_done, 1);
    check("ill6_busy", n_busy, 0);
    run_op(3'b111, 8'h00, -1);
    check("ill7_err_done", n_err_done, 1);
    check("ill7_writes", n_writes, 0);

    // A start pulse in the middle of MUL (5 * 3) must change nothing.
    run_op(3'b000, 8'h05, -1);
    run_op(3'b001, 8'h03, -1);
    run_op(3'b101, 8'h99, 4);
    check("mid_start_busy", n_busy, 12);
    check("mid_start_writes", n_writes, 8);
    check("mid_start_r2", dp_r[2], 8'h0F);
    check("mid_start_r0", dp_r[0], 8'h05);
    check("mid_start_err", n_err, 0);

    // A start in FIN is ignored. A start in the next IDLE cycle is accepted.
    op_sel = 3'b100;
    start  = 1'b1;
    step();
    start  = 1'b0;
    check("clr_exec_word", control_word, 16'h4071);
    step();
    check("clr_fin_done", done, 1'b1);
    data_in = 8'h77;
    op_sel  = 3'b000;
    start   = 1'b1;
    step();
    check("fin_start_ignored_busy", busy, 1'b0);
    check("fin_start_ignored_cw", control_word, 16'h0000);
    step();
    start = 1'b0;
    check("idle_start_accepted", control_word, 16'h0003);
    step();
    check("idle_start_done", done, 1'b1);
    step();
    check("idle_start_back_idle", busy, 1'b0);
    check("idle_start_r0", dp_r[0], 8'h77);
    check("clr_r2", dp_r[2], 8'h00);

    // Reset while in M_ADD (R0=0x77, R1=3). No further writes may occur.
    op_sel = 3'b101;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int i = 0; i < 50 && control_word != 16'h4809; i++) step();
    check("reached_m_add", control_word, 16'h4809);
    reset_b = 1'b0;
    #1;
    check("abort_cw", control_word, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    step();
    step();
    @(negedge clk);
    reset_b = 1'b1;
    step();
    step();
    check("abort_r2", dp_r[2], 8'h00);
    check("abort_r3", dp_r[3], 8'h03);
    check("abort_idle_cw", control_word, 16'h0000);
    check("abort_idle_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control-word generator that sits directly upstream of Datapath and drives its control_word and constant_in inputs.
- Replaces free-running mode stepping with a start-triggered sequencer.
- Each operation writes the register file exactly once per step; RW is never held high while idle.
- Multi-cycle MUL (repeated add) uses Datapath's Z flag as loop feedback.

Parameters:
- CW_W, 16, control word width: {DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0]}
- DATA_W, 8, Datapath data / constant width

Ports:
- clk, input, 1, system clock
- reset_b, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle pulse from debounce; launches the operation selected by op_sel
- op_sel, input, 3, operation select, sampled only on an accepted start
- z_flag, input, 1, Datapath Z; combinational from the control word presented in the same cycle
- control_word, output, CW_W, registered control word to Datapath
- constant_out, output, DATA_W, constant to Datapath; always 0 in this revision
- busy, output, 1, high from the cycle after an accepted start until FIN
- done, output, 1, one-cycle pulse in FIN
- err, output, 1, one-cycle pulse in FIN when the latched op was illegal

Behaviour:
- Reset (async, reset_b=0): state=IDLE, control_word=16'h0000 (NOP, RW=0), busy=0, done=0, err=0.
- Reset mid-operation aborts immediately; no further writes occur.
- Outputs are Moore and registered from state. The control word for a state is presented for that whole state. The Datapath write commits at the edge that leaves the state.
- IDLE:
  - Output NOP.
  - start=1 latches op_sel.
  - Next state is EXEC for ops 000–100, M_CLR for 101, FIN with err for 110/111.
- start while busy (any non-IDLE state) is ignored; op_sel is not re-latched.
- EXEC (1 cycle, then FIN). Control word by latched op:
  - 000 LOAD_A: R0<=Data_in, 16'h0003
  - 001 LOAD_B: R1<=Data_in, 16'h2003
  - 010 ADD: R2<=R0+R1, 16'h4089
  - 011 SUB: R2<=R0-R1 (FS=0101), 16'h4095
  - 100 CLEAR: R2<=constant 0 (MB=1, FS=1100), 16'h4071
- MUL (101), R2<=R0*R1 low 8 bits, with R3 as loop counter:
  - M_CLR: R2<=0, 16'h4071, then M_CPY.
  - M_CPY: R3<=R1 (DA=3, AA=1, FS=MOVA, MD=0, RW=1), 16'h6401, then M_TEST.
  - M_TEST: present AA=3, FS=MOVA, RW=0 (16'h0C00). Sample z_flag at the edge: 1 goes to FIN, 0 goes to M_ADD.
  - M_ADD: R2<=R2+R0 (DA=2, AA=2, BA=0, FS=0010, RW=1), 16'h4809, then M_DEC.
  - M_DEC: R3<=R3-1 (DA=3, AA=3, FS=0110, RW=1), 16'h6C19, then M_TEST.
- Width rule for MUL: R1 is treated as an unsigned count 0..255. The mod-256 accumulation yields the correct two's-complement low byte for signed operands.
- MUL latency:
  - busy cycles = 2 + 3n + 1 for n = unsigned R1.
  - n=0 gives 3 busy cycles and R2=0.
  - Maximum is n=255, which gives 768 busy cycles.
- FIN: NOP, done=1 for exactly one cycle, busy=1 in FIN, then IDLE.
- start arriving in the FIN cycle is ignored.
- start in the first IDLE cycle after FIN is accepted.
- Illegal op: IDLE goes to FIN with done=1 and err=1; no RW=1 cycle is issued.

Test Plan:
- Reset while in M_ADD → next sample shows control_word=16'h0000, busy=0, done=0; Datapath registers unchanged after reset release.
- LOAD_A with Data_in=5, then LOAD_B with Data_in=-3, then ADD → each start gives exactly one RW=1 cycle with words 0003/2003/4089; R2=8'h02; done pulses once per op.
- SUB with R0=2, R1=7 → control word 16'h4095 for one cycle; R2=8'hFB.
- MUL with R0=3, R1=4 against a Datapath model → busy high 15 cycles; four M_ADD writes; R2=8'h0C; R3=0. MUL with R0=-2, R1=3 → R2=8'hFA.
- MUL with R1=0 → sequence M_CLR, M_CPY, M_TEST, FIN; R2=0; no M_ADD cycle.
- op_sel=3'b110 → err=1 and done=1 in the same single cycle; no RW=1 issued. A start pulse mid-MUL changes no state or latched op.
